// File: rtl/multiplier_seq_nbit.sv
// rtl/multiplier_seq_nbit.sv - iterative shift-and-add multiplier, one multiplier bit per cycle
// Returns the low WIDTH bits of A*B behind valid/ready handshakes on input and output.

module mux_nbit #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module adder_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  // Both implementations are modulo 2^WIDTH; the final carry is dropped.
  generate
    if (IMPL_TYPE == 0) begin : g_behav
      assign sum = a + b;
    end else begin : g_ripple
      always_comb begin
        logic cy;
        cy  = 1'b0;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
          sum[i] = a[i] ^ b[i] ^ cy;
          cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
      end
    end
  endgenerate
endmodule

module multiplier_seq_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] P,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] addend, sum;
  logic             accept, last;

  mux_nbit #(.WIDTH(WIDTH)) u_mux (
    .sel (mplier[0]),
    .a   ('0),
    .b   (mcand),
    .y   (addend)
  );

  adder_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_add (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign P         = acc;
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latency is fixed at WIDTH steps; no early exit when mplier runs out of ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && accept) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// tb/tb_multiplier_seq_nbit.sv - directed and random checks for the 8-bit sequential multiplier

module tb_multiplier_seq_nbit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] P;
  logic         busy;

  int tests = 0;
  int fails = 0;

  multiplier_seq_nbit #(.WIDTH(W), .IMPL_TYPE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           stall;
    bit           toggle;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, optional stall, handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int stall, input bit toggle, input string name);
    int lat;
    int guard;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({name, "_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        A = W'($urandom);
        if (in_ready !== 1'b0) chk({name, "_ready_busy"}, in_ready, 1'b0);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, lat, W);
    chk({name, "_P"}, P, exp);
    held = P;
    for (int i = 0; i < stall; i++) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        A = W'($urandom);
      end
      tick();
      if (out_valid !== 1'b1 || P !== held || in_ready !== 1'b0) begin
        chk({name, "_stall_ov"}, out_valid, 1'b1);
        chk({name, "_stall_P"}, P, held);
        chk({name, "_stall_ready"}, in_ready, 1'b0);
      end
    end
    if (stall > 0) chk({name, "_held_P"}, P, exp);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({name, "_ov_drop"}, out_valid, 1'b0);
    chk({name, "_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'd3,   8'd5,   8'd15,  0, 1'b0};
    vecs[1] = '{8'hFF,  8'hFF,  8'h01,  0, 1'b0};
    vecs[2] = '{8'h80,  8'h02,  8'h00,  0, 1'b0};
    vecs[3] = '{8'h00,  8'h5A,  8'h00,  0, 1'b0};
    vecs[4] = '{8'h5A,  8'h00,  8'h00,  0, 1'b0};
    vecs[5] = '{8'hA5,  8'h01,  8'hA5,  0, 1'b0};
    vecs[6] = '{8'h0F,  8'h11,  8'hFF,  2, 1'b0};
    vecs[7] = '{8'h10,  8'h10,  8'h00,  0, 1'b0};
    vecs[8] = '{8'h0D,  8'h0B,  8'h8F,  1, 1'b0};
    vecs[9] = '{8'h07,  8'h09,  8'h3F,  5, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    tick();
    tick();
    chk("rst_P", P, 8'h00);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].stall, vecs[i].toggle, $sformatf("vec%0d", i));

    // Reset in the fourth BUSY cycle loses the result.
    in_valid = 1'b1; A = 8'd200; B = 8'd77;
    tick();
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_P", P, 8'h00);
    chk("mid_rst_ov", out_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) chk("mid_rst_no_pulse", out_valid, 1'b0);
    end
    run_op(8'd7, 8'd9, 8'd63, 0, 1'b0, "after_rst");

    // In DONE with in_valid and out_ready both high, only the output handshake happens.
    in_valid = 1'b1; A = 8'd6; B = 8'd7; out_ready = 1'b0;
    tick();
    A = 8'd11; B = 8'd13;
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    chk("done_in_P", P, 8'd42);
    out_ready = 1'b1;
    tick();
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_in_notbusy", busy, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("done_in_accept", busy, 1'b1);
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    chk("done_in_P2", P, 8'd143);
    tick();

    // Random pairs against an arithmetic model, random stalls.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic [15:0]  full;
      ra = W'($urandom);
      rb = W'($urandom);
      full = ra * rb;
      run_op(ra, rb, full[W-1:0], $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
